// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: exhaustive stimulus/check stage for a small
// combinational block. Walks every input vector in ascending order, holds each
// one for SETTLE cycles, samples y_in on the following cycle and compares it
// against the golden truth table EXPECTED.
//
// Handshake: start is a level-sampled request, accepted only on a clock edge
// where the FSM is in IDLE or DONE; busy is high from the accept edge until the
// last vector has been checked, and done (with pass/err_count/fail_valid/
// first_fail_idx) is then held until the next accepted start or reset.
//
// Optional build macro: TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN adds the per-vector
// fail_mask output.
// state_dbg exposes the FSM state: 0=IDLE, 1=WAIT, 2=CHECK, 3=DONE.
module truth_table_sequencer #(
  parameter int                  N_IN     = 3,
  parameter logic [2**N_IN-1:0]  EXPECTED = 8'h31,
  parameter int                  SETTLE   = 2      // must be >= 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail_idx,
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
  output logic [2**N_IN-1:0]   fail_mask,
`endif
  output logic [1:0]           state_dbg
);

  localparam int                NV        = 2**N_IN;
  localparam int                WAIT_W    = $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0]   LAST_IDX  = N_IN'(NV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N_IN-1:0]   idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              launch;
  logic              mismatch;

  // A run may only be (re)started from a quiescent state.
  assign launch   = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign mismatch = (state == S_CHECK) && (y_in != EXPECTED[idx]);
  assign vec_out  = idx;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: WAIT for SETTLE cycles, one CHECK cycle per vector.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WAIT;
      S_WAIT:         if (wait_cnt == WAIT_LAST) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (idx == LAST_IDX) ? S_DONE : S_WAIT;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state; pass is only asserted alongside done.
  always_comb begin
    busy      = (state == S_WAIT) || (state == S_CHECK);
    done      = (state == S_DONE);
    pass      = (state == S_DONE) && (err_count == '0);
    state_dbg = state;
  end

  // Vector index and settle counter; idx stops at the last vector (no wrap).
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      idx      <= '0;
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else if (state == S_CHECK && idx != LAST_IDX) begin
      idx      <= idx + 1'b1;
      wait_cnt <= '0;
    end
  end

  // Result registers: cleared on reset and on every accepted start.
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (mismatch) begin
      err_count <= err_count + 1'b1;
      if (!fail_valid) begin
        fail_valid     <= 1'b1;
        first_fail_idx <= idx;
      end
    end
  end

`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
  // One sticky bit per vector that mismatched in the current run.
  always_ff @(posedge clk) begin
    if (reset || launch) fail_mask      <= '0;
    else if (mismatch)   fail_mask[idx] <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a behavioural block-under-test model drives
// y_in, a driver issues runs and pushes predicted results into exp_q, and a
// negedge monitor compares the DUT against the prediction.
module tb_truth_table_sequencer;

  localparam int          N_IN = 3;
  localparam int          NV   = 8;
  localparam int          S    = 2;
  localparam int          RUN  = NV * (S + 1);   // 24
  localparam int          RUN1 = NV * (1 + 1);   // 16, SETTLE=1 instance
  localparam logic [7:0]  GOLD = 8'h31;
  localparam int          W    = 17;             // {mask, err, ffi, fv, pass}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (SETTLE=2) ----------------
  logic             start = 1'b0;
  logic [N_IN-1:0]  vec_out;
  logic             y_in;
  logic             busy, done, pass, fail_valid;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_fail_idx;
  logic [1:0]       state_dbg;
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
  logic [NV-1:0]    fail_mask;
`endif

  truth_table_sequencer #(.N_IN(N_IN), .EXPECTED(GOLD), .SETTLE(S)) u_dut (
    .clk(clk), .reset(reset), .start(start), .vec_out(vec_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_idx(first_fail_idx),
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
    .fail_mask(fail_mask),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- DUT (SETTLE=1) ----------------
  logic             start1 = 1'b0;
  logic [N_IN-1:0]  vec_out1;
  logic             y_in1;
  logic             busy1, done1, pass1, fail_valid1;
  logic [N_IN:0]    err_count1;
  logic [N_IN-1:0]  first_fail_idx1;
  logic [1:0]       state_dbg1;
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
  logic [NV-1:0]    fail_mask1;
`endif

  truth_table_sequencer #(.N_IN(N_IN), .EXPECTED(GOLD), .SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .vec_out(vec_out1), .y_in(y_in1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .first_fail_idx(first_fail_idx1),
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
    .fail_mask(fail_mask1),
`endif
    .state_dbg(state_dbg1)
  );

  // ---------------- block-under-test models ----------------
  // 0: correct sillyfunction, 1: stuck-at-1, 2: inverted golden, 3: random table
  int         mode = 0;
  logic [7:0] rtab = 8'h00;

  function automatic logic but_model(input int m, input logic [2:0] v, input logic [7:0] t);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    case (m)
      0:       return (~b & ~c) | (a & ~b);
      1:       return 1'b1;
      2:       return ~GOLD[v];
      default: return t[v];
    endcase
  endfunction

  always_comb y_in  = but_model(mode, vec_out, rtab);
  always_comb y_in1 = but_model(0, vec_out1, 8'h00);

  // Whole-run prediction straight from the truth-table rules.
  function automatic logic [W-1:0] predict(input int m, input logic [7:0] t);
    logic [7:0] mask;
    int         err, ffi;
    logic       fv, mm;
    mask = '0; err = 0; ffi = 0; fv = 1'b0;
    for (int i = 0; i < NV; i++) begin
      mm = (but_model(m, 3'(i), t) != GOLD[i]);
      mask[i] = mm;
      if (mm) begin
        err++;
        if (!fv) begin fv = 1'b1; ffi = i; end
      end
    end
    return {mask, 4'(err), 3'(ffi), fv, (err == 0)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int acc  = -1;   // accept edge of the current run on u_dut, -1 = none
  int acc1 = -1;   // same for u_dut1
  int n_tests = 0;
  int n_fail  = 0;
  logic rst_pend = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples every negedge, away from the active edge.
  always @(negedge clk) begin
    int e, e1;
    logic [W-1:0] x;
    if (reset) begin
      rst_pend = 1'b1;
      exp_q.delete();
    end else begin
      if (rst_pend) begin
        rst_pend = 1'b0;
        check("rst_state", int'(state_dbg), 0);
        check("rst_vec", int'(vec_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_fv", int'(fail_valid), 0);
        check("rst_ffi", int'(first_fail_idx), 0);
        check("rst_busy1", int'(busy1), 0);
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
        check("rst_mask", int'(fail_mask), 0);
`endif
      end
      if (acc >= 0) begin
        e = cyc - acc;
        if (e >= 0 && e < RUN) begin
          check("run_vec", int'(vec_out), e / (S + 1));
          check("run_busy", int'(busy), 1);
          check("run_done", int'(done), 0);
        end else if (e == RUN) begin
          check("done_at_latency", int'(done), 1);
          check("done_busy", int'(busy), 0);
          check("done_vec_hold", int'(vec_out), NV - 1);
          if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
          end else begin
            x = exp_q.pop_front();
            check("pass", int'(pass), int'(x[0]));
            check("fail_valid", int'(fail_valid), int'(x[1]));
            if (x[1]) check("first_fail_idx", int'(first_fail_idx), int'(x[4:2]));
            check("err_count", int'(err_count), int'(x[8:5]));
`ifdef TRUTH_TABLE_SEQUENCER_FAIL_MASK_EN
            check("fail_mask", int'(fail_mask), int'(x[16:9]));
`endif
          end
        end
      end
      if (acc1 >= 0) begin
        e1 = cyc - acc1;
        if (e1 >= 0 && e1 < RUN1) begin
          check("s1_vec", int'(vec_out1), e1 / 2);
          check("s1_done", int'(done1), 0);
        end else if (e1 == RUN1) begin
          check("s1_done_at_latency", int'(done1), 1);
          check("s1_pass", int'(pass1), 1);
          check("s1_err", int'(err_count1), 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run(input int m, input logic [7:0] t);
    mode  = m;
    rtab  = t;
    start = 1'b1;
    acc   = cyc + 1;
    exp_q.push_back(predict(m, t));
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_reset(input logic with_start);
    reset = 1'b1;
    start = with_start;
    acc   = -1;
    acc1  = -1;
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);

    // Correct, stuck-at-1 and inverted blocks.
    for (int m = 0; m < 3; m++) begin
      start_run(m, 8'h00);
      tick(RUN + 2);
    end

    // Randomised blocks and random truth tables.
    for (int k = 0; k < 6; k++) begin
      start_run(int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      tick(RUN + int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a run, then a clean run.
    start_run(1, 8'h00);
    tick(9);
    pulse_reset(1'b0);
    start_run(0, 8'h00);
    tick(RUN + 2);

    // Starts during a run are ignored; start in DONE restarts immediately.
    start_run(1, 8'h00);
    tick(4);
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    start = 1'b1; tick(1); start = 1'b0;
    tick(RUN - 12 + 2);
    start_run(2, 8'h00);
    tick(RUN + 2);

    // Reset and start together: reset wins.
    pulse_reset(1'b1);
    tick(2);

    // SETTLE=1 build with the correct block.
    start1 = 1'b1;
    acc1   = cyc + 1;
    tick(1);
    start1 = 1'b0;
    tick(RUN1 + 3);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL exp_q_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
